// File: rtl/adc_frame_packer.sv
`default_nettype none
// ============================================================================
//  Module   : adc_frame_packer
//  Purpose  : Multi-channel ADC capture with per-channel decimation, raw or
//             processed source select, and framed valid/ready word stream.
//  Revision : 1.0  initial release
// ============================================================================
module adc_frame_packer #(
  parameter int N_CH      = 2,
  parameter int DATA_W    = 16,
  parameter int BLOCK_LEN = 128,
  parameter int DECIM_W   = 8,
  parameter int OVR_W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [N_CH-1:0]          ch_en,
  input  logic [N_CH-1:0]          src_sel,
  input  logic [DECIM_W-1:0]       decim,
  input  logic [N_CH-1:0]          adc_cs,
  input  logic [N_CH*DATA_W-1:0]   adc_data,
  input  logic [N_CH*DATA_W-1:0]   alt_data,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  output logic                     out_last,
  input  logic                     out_ready,
  output logic [15:0]              frame_seq,
  output logic [N_CH*OVR_W-1:0]    overrun_cnt,
  output logic                     overrun_err
);

  localparam int c_CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int c_GRP_W = $clog2(BLOCK_LEN + 1);
  localparam logic [c_GRP_W-1:0] c_GRP_LAST = c_GRP_W'(BLOCK_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HDR  = 2'd2,
    S_DATA = 2'd3
  } state_t;

  state_t               r_state;
  logic [N_CH-1:0]      r_ch_lat;
  logic [N_CH-1:0]      r_src_lat;
  logic [DECIM_W-1:0]   r_decim_lat;
  logic [c_GRP_W-1:0]   r_grp_cnt;
  logic [c_CH_W-1:0]    r_ch;
  logic [DATA_W-1:0]    r_data;
  logic                 r_valid;
  logic                 r_last;
  logic [15:0]          r_frame_seq;
  logic                 r_ovr_err;

  logic [N_CH-1:0]      w_pend;
  logic [N_CH-1:0]      w_clr;
  logic [N_CH-1:0]      w_ovr_hit;
  logic [DATA_W-1:0]    w_hold [N_CH];
  logic [c_CH_W-1:0]    w_first_ch;
  logic [c_CH_W-1:0]    w_next_ch;
  logic [c_CH_W-1:0]    w_last_ch;
  logic [DATA_W-1:0]    w_hdr;
  logic                 w_grp_last;
  logic                 w_all_pend;
  logic                 w_hdr_go;
  logic                 w_xfer;

  assign w_grp_last = (r_grp_cnt == c_GRP_LAST);
  assign w_all_pend = ((w_pend & r_ch_lat) == r_ch_lat);
  assign w_hdr_go   = (r_state == S_WAIT) && start && w_all_pend && (r_grp_cnt == '0);
  assign w_xfer     = (r_state == S_DATA) && out_ready;
  // Header reflects the configuration being latched in the same cycle
  assign w_hdr      = DATA_W'({4'hA, r_frame_seq[3:0], 8'(ch_en)});

  always_comb begin
    w_first_ch = '0;
    w_next_ch  = '0;
    w_last_ch  = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (r_ch_lat[k]) w_first_ch = c_CH_W'(k);
      if (r_ch_lat[k] && (c_CH_W'(k) > r_ch)) w_next_ch = c_CH_W'(k);
    end
    for (int k = 0; k < N_CH; k++) begin
      if (r_ch_lat[k]) w_last_ch = c_CH_W'(k);
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic               r_cs_meta;
    logic               r_cs_sync;
    logic               r_cs_prev;
    logic               r_pend;
    logic [DECIM_W-1:0] r_dcnt;
    logic [OVR_W-1:0]   r_ovr;
    logic [DATA_W-1:0]  r_hold;
    logic               w_strobe;
    logic               w_accept;
    logic               w_keep;
    logic               w_busy;

    assign w_strobe = r_cs_sync & ~r_cs_prev;
    assign w_accept = w_strobe && (r_dcnt == r_decim_lat);
    assign w_keep   = w_accept && r_ch_lat[k] && (r_state != S_IDLE);
    // A word leaving this cycle frees the slot for a sample arriving now
    assign w_busy   = r_pend && !w_clr[k];
    assign w_clr[k] = (w_xfer && (r_ch == c_CH_W'(k))) || (w_hdr_go && !ch_en[k]);

    always_ff @(posedge clk) begin
      if (rst) begin
        r_cs_meta <= 1'b0;
        r_cs_sync <= 1'b0;
        r_cs_prev <= 1'b0;
        r_pend    <= 1'b0;
        r_dcnt    <= '0;
        r_ovr     <= '0;
        r_hold    <= '0;
      end else begin
        r_cs_meta <= adc_cs[k];
        r_cs_sync <= r_cs_meta;
        r_cs_prev <= r_cs_sync;

        if (r_state == S_IDLE)
          r_dcnt <= '0;
        else if (w_strobe)
          r_dcnt <= w_accept ? '0 : r_dcnt + 1'b1;

        if (r_state == S_IDLE) begin
          r_pend <= 1'b0;
        end else if (w_keep && !w_busy) begin
          r_pend <= 1'b1;
          r_hold <= r_src_lat[k] ? alt_data[k*DATA_W +: DATA_W]
                                 : adc_data[k*DATA_W +: DATA_W];
        end else if (w_clr[k]) begin
          r_pend <= 1'b0;
        end

        if (w_keep && w_busy && (r_ovr != '1))
          r_ovr <= r_ovr + 1'b1;
      end
    end

    assign w_pend[k]    = r_pend;
    assign w_hold[k]    = r_hold;
    assign w_ovr_hit[k] = w_keep && w_busy;
    assign overrun_cnt[k*OVR_W +: OVR_W] = r_ovr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ch_lat    <= '0;
      r_src_lat   <= '0;
      r_decim_lat <= '0;
      r_grp_cnt   <= '0;
      r_ch        <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_frame_seq <= '0;
      r_ovr_err   <= 1'b0;
    end else begin
      if (|w_ovr_hit) r_ovr_err <= 1'b1;

      case (r_state)
        S_IDLE: begin
          r_valid <= 1'b0;
          r_last  <= 1'b0;
          if (start && (ch_en != '0)) begin
            r_ch_lat    <= ch_en;
            r_src_lat   <= src_sel;
            r_decim_lat <= decim;
            r_grp_cnt   <= '0;
            r_state     <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (!start) begin
            r_state <= S_IDLE;
          end else if (w_hdr_go) begin
            r_ch_lat    <= ch_en;
            r_src_lat   <= src_sel;
            r_decim_lat <= decim;
            r_data      <= w_hdr;
            r_valid     <= 1'b1;
            r_last      <= 1'b0;
            r_state     <= S_HDR;
          end else if (w_all_pend) begin
            r_ch    <= w_first_ch;
            r_data  <= w_hold[w_first_ch];
            r_valid <= 1'b1;
            r_last  <= w_grp_last && (w_first_ch == w_last_ch);
            r_state <= S_DATA;
          end
        end

        S_HDR: begin
          if (out_ready) begin
            r_ch    <= w_first_ch;
            r_data  <= w_hold[w_first_ch];
            r_last  <= w_grp_last && (w_first_ch == w_last_ch);
            r_state <= S_DATA;
          end
        end

        S_DATA: begin
          if (out_ready) begin
            if (r_ch == w_last_ch) begin
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_state <= S_WAIT;
              if (w_grp_last) begin
                r_grp_cnt   <= '0;
                r_frame_seq <= r_frame_seq + 16'd1;
              end else begin
                r_grp_cnt <= r_grp_cnt + 1'b1;
              end
            end else begin
              r_ch   <= w_next_ch;
              r_data <= w_hold[w_next_ch];
              r_last <= w_grp_last && (w_next_ch == w_last_ch);
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_data    = r_data;
  assign out_valid   = r_valid;
  assign out_last    = r_last;
  assign frame_seq   = r_frame_seq;
  assign overrun_err = r_ovr_err;

endmodule
`default_nettype wire

// File: tb/tb_adc_frame_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adc_frame_packer
//  Purpose  : Directed self-checking bench for adc_frame_packer (2 ch, 4 groups)
//  Revision : 1.0  initial release
// ============================================================================
module tb_adc_frame_packer;

  localparam int N_CH      = 2;
  localparam int DATA_W    = 16;
  localparam int BLOCK_LEN = 4;
  localparam int DECIM_W   = 8;
  localparam int OVR_W     = 8;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic [N_CH-1:0]        ch_en;
  logic [N_CH-1:0]        src_sel;
  logic [DECIM_W-1:0]     decim;
  logic [N_CH-1:0]        adc_cs;
  logic [N_CH*DATA_W-1:0] adc_data;
  logic [N_CH*DATA_W-1:0] alt_data;
  logic [DATA_W-1:0]      out_data;
  logic                   out_valid;
  logic                   out_last;
  logic                   out_ready;
  logic [15:0]            frame_seq;
  logic [N_CH*OVR_W-1:0]  overrun_cnt;
  logic                   overrun_err;

  int n_checks = 0;
  int n_pass   = 0;
  logic [16:0] cap_q [$];

  adc_frame_packer #(
    .N_CH(N_CH), .DATA_W(DATA_W), .BLOCK_LEN(BLOCK_LEN),
    .DECIM_W(DECIM_W), .OVR_W(OVR_W)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .ch_en(ch_en), .src_sel(src_sel),
    .decim(decim), .adc_cs(adc_cs), .adc_data(adc_data), .alt_data(alt_data),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .frame_seq(frame_seq), .overrun_cnt(overrun_cnt),
    .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  // Words that will transfer on the coming rising edge, stored as {last, data}
  always @(negedge clk) begin
    if (out_valid && out_ready) cap_q.push_back({out_last, out_data});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic chk_word(input string tag, input int idx, input logic [16:0] exp);
    logic [16:0] got;
    got = (idx < cap_q.size()) ? cap_q[idx] : 17'h1FFFF;
    check(tag, 32'(got), 32'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    cap_q.delete();
    tick();
  endtask

  task automatic cs_pulse(input logic [15:0] n, input int hi, input int lo);
    adc_data = {16'h0200 + n, 16'h0100 + n};
    alt_data = {16'hBEEF, 16'hDEAD};
    adc_cs   = 2'b11;
    repeat (hi) tick();
    adc_cs = 2'b00;
    repeat (lo) tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ch_en = 2'b11; src_sel = 2'b00; decim = '0;
    adc_cs = '0; adc_data = '0; alt_data = '0; out_ready = 1'b1;
    repeat (3) tick();
    check("rst_valid", 32'(out_valid), 0);
    check("rst_last", 32'(out_last), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_seq", 32'(frame_seq), 0);
    check("rst_ovr", 32'(overrun_cnt), 0);
    check("rst_err", 32'(overrun_err), 0);

    // Full frame of 4 groups, then first group of the next frame
    do_reset();
    start = 1'b1;
    repeat (4) tick();
    for (int n = 0; n < 5; n++) cs_pulse(16'(n), 4, 4);
    repeat (8) tick();
    chk_word("t1_hdr0", 0, 17'h0A003);
    for (int g = 0; g < 4; g++) begin
      chk_word($sformatf("t1_g%0d_ch0", g), 1 + 2*g, {1'b0, 16'h0100 + 16'(g)});
      chk_word($sformatf("t1_g%0d_ch1", g), 2 + 2*g, {(g == 3), 16'h0200 + 16'(g)});
    end
    chk_word("t1_hdr1", 9, 17'h0A103);
    chk_word("t1_f1_ch0", 10, 17'h00104);
    chk_word("t1_f1_ch1", 11, 17'h00204);
    check("t1_nwords", cap_q.size(), 12);
    check("t1_seq", 32'(frame_seq), 1);

    // Source select: ch1 from processed path
    do_reset();
    src_sel = 2'b10;
    start = 1'b1;
    repeat (4) tick();
    cs_pulse(16'h0010, 4, 4);
    repeat (8) tick();
    chk_word("t2_hdr", 0, 17'h0A003);
    chk_word("t2_ch0", 1, 17'h00110);
    chk_word("t2_ch1", 2, 17'h0BEEF);

    // Decimation by 3: the 3rd and 6th edges are kept
    do_reset();
    src_sel = 2'b00;
    decim = 8'd2;
    start = 1'b1;
    repeat (4) tick();
    for (int n = 0; n < 6; n++) cs_pulse(16'h0020 + 16'(n), 4, 4);
    repeat (8) tick();
    chk_word("t3_hdr", 0, 17'h0A003);
    chk_word("t3_a_ch0", 1, 17'h00122);
    chk_word("t3_a_ch1", 2, 17'h00222);
    chk_word("t3_b_ch0", 3, 17'h00125);
    chk_word("t3_b_ch1", 4, 17'h00225);
    check("t3_nwords", cap_q.size(), 5);
    check("t3_ovr", 32'(overrun_cnt), 0);

    // Backpressure: header held, later samples dropped and counted
    do_reset();
    decim = '0;
    out_ready = 1'b0;
    start = 1'b1;
    repeat (4) tick();
    cs_pulse(16'h0030, 4, 4);
    for (int n = 0; n < 10; n++) cs_pulse(16'h0040, 2, 2);
    repeat (4) tick();
    check("t4_hold_valid", 32'(out_valid), 1);
    check("t4_hold_data", 32'(out_data), 32'h0000A003);
    check("t4_ovr_10", 32'(overrun_cnt), 32'h00000A0A);
    check("t4_err", 32'(overrun_err), 1);
    for (int n = 0; n < 250; n++) cs_pulse(16'h0050, 2, 2);
    repeat (4) tick();
    check("t4_ovr_sat", 32'(overrun_cnt), 32'h0000FFFF);
    check("t4_hold_data2", 32'(out_data), 32'h0000A003);
    out_ready = 1'b1;
    repeat (8) tick();
    chk_word("t4_hdr", 0, 17'h0A003);
    chk_word("t4_ch0", 1, 17'h00130);
    chk_word("t4_ch1", 2, 17'h00230);

    // Start dropped while group 2 is in flight: group completes, no out_last
    do_reset();
    start = 1'b1;
    repeat (4) tick();
    cs_pulse(16'h0000, 4, 4);
    cs_pulse(16'h0001, 4, 4);
    adc_data = {16'h0202, 16'h0102};
    adc_cs = 2'b11;
    repeat (5) tick();
    start = 1'b0;
    repeat (3) tick();
    adc_cs = 2'b00;
    repeat (6) tick();
    check("t5_nwords", cap_q.size(), 7);
    chk_word("t5_g2_ch0", 5, 17'h00102);
    chk_word("t5_g2_ch1", 6, 17'h00202);
    check("t5_idle_valid", 32'(out_valid), 0);
    check("t5_seq", 32'(frame_seq), 0);
    cap_q.delete();
    start = 1'b1;
    repeat (4) tick();
    cs_pulse(16'h0003, 4, 4);
    repeat (8) tick();
    chk_word("t5_rehdr", 0, 17'h0A003);
    chk_word("t5_re_ch0", 1, 17'h00103);
    chk_word("t5_re_ch1", 2, 17'h00203);

    // Channel mask change mid-frame applies from the next header
    do_reset();
    ch_en = 2'b11;
    start = 1'b1;
    repeat (4) tick();
    cs_pulse(16'h0000, 4, 4);
    ch_en = 2'b01;
    for (int n = 1; n < 6; n++) cs_pulse(16'(n), 4, 4);
    repeat (8) tick();
    chk_word("t6_g1_ch1", 4, 17'h00201);
    chk_word("t6_last", 8, 17'h10203);
    chk_word("t6_hdr1", 9, 17'h0A101);
    chk_word("t6_f1_g0", 10, 17'h00104);
    chk_word("t6_f1_g1", 11, 17'h00105);
    check("t6_nwords", cap_q.size(), 12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
